// File: rtl/spram_stream_reader_pkg.sv
// Shared types and constants for spram_stream_reader and its prefetch buffer.
package spram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH  = 2;
  localparam int RD_LATENCY = 1;
  localparam int OCC_WIDTH  = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/vr_skid_buf.sv
// Two-entry valid/ready prefetch buffer; entry 0 is the registered stream head.
// Optional per-entry last bit when SPRAM_STREAM_READER_LAST_EN is defined.
module vr_skid_buf
  import spram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
`ifdef SPRAM_STREAM_READER_LAST_EN
  input  logic                  push_last,
  output logic                  head_last,
`endif
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [OCC_WIDTH-1:0]  occupancy
);

  logic [DATA_WIDTH-1:0] d0_q, d1_q;
  logic                  v0_q, v1_q;
  logic                  pop_ok;

  assign pop_ok     = pop & v0_q;
  assign head_data  = d0_q;
  assign head_valid = v0_q;
  assign occupancy  = OCC_WIDTH'(v0_q) + OCC_WIDTH'(v1_q);

  // Entry 1 is only ever occupied while entry 0 is, so the head is always d0.
  always_ff @(posedge clk) begin
    if (rst) begin
      d0_q <= '0;
      d1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      unique case ({push, pop_ok})
        2'b11: begin
          if (v1_q) begin
            d0_q <= d1_q;
            d1_q <= push_data;
          end else begin
            d0_q <= push_data;
          end
        end
        2'b01: begin
          d0_q <= d1_q;
          v0_q <= v1_q;
          v1_q <= 1'b0;
        end
        2'b10: begin
          if (!v0_q) begin
            d0_q <= push_data;
            v0_q <= 1'b1;
          end else begin
            d1_q <= push_data;
            v1_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPRAM_STREAM_READER_LAST_EN
  logic l0_q, l1_q;

  assign head_last = l0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      l0_q <= 1'b0;
      l1_q <= 1'b0;
    end else begin
      unique case ({push, pop_ok})
        2'b11: begin
          if (v1_q) begin
            l0_q <= l1_q;
            l1_q <= push_last;
          end else begin
            l0_q <= push_last;
          end
        end
        2'b01: begin
          l0_q <= l1_q;
          l1_q <= 1'b0;
        end
        2'b10: begin
          if (!v0_q) l0_q <= push_last;
          else       l1_q <= push_last;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: rtl/spram_stream_reader.sv
// Streams a (base, length) window out of a single-port SRAM as a bubble-free
// valid/ready stream. Define SPRAM_STREAM_READER_LAST_EN to add out_last.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | issuing reads while buffer credit allows
// DRAIN | all reads issued, waiting for the buffer to empty
module spram_stream_reader
  import spram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 32,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef SPRAM_STREAM_READER_LAST_EN
  output logic                  out_last,
`endif
  output logic                  busy
);

  localparam int CW = OCC_WIDTH + 1;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   remain_q;
  logic [RD_LATENCY-1:0]  rd_pipe_q;
  logic [OCC_WIDTH-1:0]   occupancy;
  logic                   inflight;
  logic                   pop;
  logic                   issue;
  logic                   last_issue;
  logic                   drained;
  logic [CW-1:0]          credit_used;
  logic [CW-1:0]          credit_avail;

  assign inflight     = rd_pipe_q[RD_LATENCY-1];
  assign pop          = out_valid & out_ready;
  // occupancy + inflight - pop < depth, kept non-negative by moving pop across
  assign credit_used  = CW'(occupancy) + CW'(inflight);
  assign credit_avail = CW'(BUF_DEPTH) + CW'(pop);
  assign issue        = (state_q == RUN) && (credit_used < credit_avail) && !rst;
  assign last_issue   = issue && (remain_q == LEN_WIDTH'(1));
  assign drained      = !inflight && (occupancy == OCC_WIDTH'(pop));

  assign mem_rd_en = issue;
  assign mem_addr  = addr_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q <= RD_LATENCY'({rd_pipe_q, issue});
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            remain_q <= cmd_len;
            if (cmd_len != '0) state_q <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            addr_q   <= (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (last_issue) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPRAM_STREAM_READER_LAST_EN
  logic last_inflight_q;

  always_ff @(posedge clk) begin
    if (rst) last_inflight_q <= 1'b0;
    else     last_inflight_q <= last_issue;
  end
`endif

  vr_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (mem_rdata),
`ifdef SPRAM_STREAM_READER_LAST_EN
    .push_last (last_inflight_q),
    .head_last (out_last),
`endif
    .pop       (pop),
    .head_data (out_data),
    .head_valid(out_valid),
    .occupancy (occupancy)
  );

endmodule
